// File: rtl/figure_grid_compositor.sv
// Shape-selection screen compositor: grid/zoom cursor FSM plus a 2-stage pixel pipeline.
// Define SEL_BLINK_EN to build the frame counter that blinks the selection ring.
module figure_grid_compositor #(
    parameter int GRID_COLS    = 3,
    parameter int GRID_ROWS    = 3,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int TOP          = 25,
    parameter int RGB_W        = 3,
    parameter int SEL_W        = 4,
    parameter int BLINK_FRAMES = 30,
    parameter logic [RGB_W-1:0] FIG_COLOR    = 3'b001,
    parameter logic [RGB_W-1:0] SEL_COLOR    = 3'b100,
    parameter logic [RGB_W-1:0] BORDER_COLOR = 3'b110,
    parameter logic [RGB_W-1:0] BG_COLOR     = 3'b000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [9:0]                     HCount,
    input  logic [9:0]                     VCount,
    input  logic                           video_on,
    input  logic                           frame_start,
    input  logic [GRID_COLS*GRID_ROWS-1:0] fig_on,
    input  logic                           text_on,
    input  logic                           move_left,
    input  logic                           move_right,
    input  logic                           move_up,
    input  logic                           move_down,
    input  logic                           enter,
    input  logic                           back,
    output logic [((GRID_COLS*GRID_ROWS) > 1 ? $clog2(GRID_COLS*GRID_ROWS) : 1)-1:0] sel_index,
    output logic                           full_screen,
    output logic [RGB_W-1:0]               rgb
);

    // state  | meaning
    // S_GRID | all cells shown, moves steer the cursor, enter zooms
    // S_ZOOM | only the selected figure shown, back returns to grid

    localparam int N_CELLS = GRID_COLS * GRID_ROWS;
    localparam int SEL_IW  = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;
    localparam int COL_W   = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
    localparam int ROW_W   = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;

    localparam logic [15:0] CELL_W = 16'(H_ACTIVE / GRID_COLS);
    localparam logic [15:0] CELL_H = 16'((V_ACTIVE - TOP) / GRID_ROWS);
    localparam logic [15:0] TOP_Y  = 16'(TOP);
    localparam logic [15:0] GRID_W = 16'(GRID_COLS * (H_ACTIVE / GRID_COLS));
    localparam logic [15:0] GRID_H = 16'(GRID_ROWS * ((V_ACTIVE - TOP) / GRID_ROWS));
    localparam logic [15:0] RING_T = 16'(SEL_W);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(GRID_COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(GRID_ROWS - 1);

    localparam logic [0:0] S_GRID = 1'b0;
    localparam logic [0:0] S_ZOOM = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_n;
    logic [COL_W-1:0] sel_col;
    logic [COL_W-1:0] col_n;
    logic [ROW_W-1:0] sel_row;
    logic [ROW_W-1:0] row_n;

    logic [COL_W-1:0]  disp_col;
    logic [ROW_W-1:0]  disp_row;
    logic [SEL_IW-1:0] sel_disp;
    logic              zoom_disp;
    logic              blink;

    // Cursor FSM: enter beats any move, moves are mutually exclusive by priority.
    always_comb begin
        state_n = state;
        col_n   = sel_col;
        row_n   = sel_row;
        if (state == S_GRID) begin
            if (enter) begin
                state_n = S_ZOOM;
            end else if (move_left) begin
                col_n = (sel_col == '0) ? LAST_COL : sel_col - COL_W'(1);
            end else if (move_right) begin
                col_n = (sel_col == LAST_COL) ? '0 : sel_col + COL_W'(1);
            end else if (move_up) begin
                row_n = (sel_row == '0) ? LAST_ROW : sel_row - ROW_W'(1);
            end else if (move_down) begin
                row_n = (sel_row == LAST_ROW) ? '0 : sel_row + ROW_W'(1);
            end
        end else if (back) begin
            state_n = S_GRID;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_GRID;
            sel_col   <= '0;
            sel_row   <= '0;
            sel_index <= '0;
        end else begin
            state     <= state_n;
            sel_col   <= col_n;
            sel_row   <= row_n;
            sel_index <= SEL_IW'(row_n) * SEL_IW'(GRID_COLS) + SEL_IW'(col_n);
        end
    end

    // Display copies only move at frame boundaries so a frame never shows two cursors.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_col  <= '0;
            disp_row  <= '0;
            sel_disp  <= '0;
            zoom_disp <= 1'b0;
        end else if (frame_start) begin
            disp_col  <= sel_col;
            disp_row  <= sel_row;
            sel_disp  <= sel_index;
            zoom_disp <= (state == S_ZOOM);
        end
    end

    assign full_screen = zoom_disp;

`ifdef SEL_BLINK_EN
    localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BC_W-1:0] blink_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= '0;
            blink     <= 1'b1;
        end else if (frame_start) begin
            if (blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + BC_W'(1);
            end
        end
    end
`else
    // Ring drawn every frame when blinking is not built.
    assign blink = (BLINK_FRAMES >= 1);
`endif

    logic [15:0]      px;
    logic [15:0]      py;
    logic [COL_W-1:0] pix_col;
    logic [ROW_W-1:0] pix_row;
    logic             v_band;
    logic             h_band;
    logic             in_grid;
    logic [15:0]      dx;
    logic [15:0]      dy;
    logic             near_edge;
    logic             ring_hit;

    assign px = 16'(HCount);
    assign py = 16'(VCount);

    // Cell lookup by threshold compare; px+1 form avoids underflow on the k*CELL_W-1 edge.
    always_comb begin
        pix_col = '0;
        pix_row = '0;
        v_band  = 1'b0;
        h_band  = 1'b0;
        for (int k = 1; k < GRID_COLS; k++) begin
            if (px >= 16'(k) * CELL_W) begin
                pix_col = COL_W'(k);
            end
            if ((px + 16'd1 >= 16'(k) * CELL_W) && (px <= 16'(k) * CELL_W + 16'd1)) begin
                v_band = 1'b1;
            end
        end
        for (int k = 1; k < GRID_ROWS; k++) begin
            if (py >= TOP_Y + 16'(k) * CELL_H) begin
                pix_row = ROW_W'(k);
            end
        end
        for (int k = 0; k <= GRID_ROWS; k++) begin
            if ((py == TOP_Y + 16'(k) * CELL_H) || (py == TOP_Y + 16'(k) * CELL_H + 16'd1)) begin
                h_band = 1'b1;
            end
        end
    end

    assign in_grid = (px < GRID_W) && (py >= TOP_Y) && (py < TOP_Y + GRID_H);
    assign dx      = px - 16'(pix_col) * CELL_W;
    assign dy      = py - (TOP_Y + 16'(pix_row) * CELL_H);

    assign near_edge = (dx < RING_T) || ((CELL_W - 16'd1 - dx) < RING_T) ||
                       (dy < RING_T) || ((CELL_H - 16'd1 - dy) < RING_T);

    assign ring_hit = in_grid && (pix_col == disp_col) && (pix_row == disp_row) &&
                      near_edge && blink;

    logic s1_video;
    logic s1_any_fig;
    logic s1_sel_fig;
    logic s1_text;
    logic s1_ring;
    logic s1_border;
    logic s1_zoom;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_video   <= 1'b0;
            s1_any_fig <= 1'b0;
            s1_sel_fig <= 1'b0;
            s1_text    <= 1'b0;
            s1_ring    <= 1'b0;
            s1_border  <= 1'b0;
            s1_zoom    <= 1'b0;
        end else begin
            s1_video   <= video_on;
            s1_any_fig <= |fig_on;
            s1_sel_fig <= fig_on[sel_disp];
            s1_text    <= text_on;
            s1_ring    <= ring_hit;
            s1_border  <= v_band || h_band;
            s1_zoom    <= zoom_disp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb <= '0;
        end else if (!s1_video) begin
            rgb <= '0;
        end else if (s1_zoom) begin
            rgb <= (s1_sel_fig || s1_text) ? FIG_COLOR : BG_COLOR;
        end else if (s1_any_fig || s1_text) begin
            rgb <= FIG_COLOR;
        end else if (s1_ring) begin
            rgb <= SEL_COLOR;
        end else if (s1_border) begin
            rgb <= BORDER_COLOR;
        end else begin
            rgb <= BG_COLOR;
        end
    end

endmodule

// File: tb/tb_figure_grid_compositor.sv
// Directed bench for figure_grid_compositor with a 3x3 grid on a 640x480 screen.
module tb_figure_grid_compositor;

`ifdef SEL_BLINK_EN
    localparam int BF       = 2;
    localparam bit BLINK_ON = 1'b1;
`else
    localparam int BF       = 30;
    localparam bit BLINK_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] HCount;
    logic [9:0] VCount;
    logic       video_on;
    logic       frame_start;
    logic [8:0] fig_on;
    logic       text_on;
    logic       move_left, move_right, move_up, move_down, enter, back;
    logic [3:0] sel_index;
    logic       full_screen;
    logic [2:0] rgb;

    int checks = 0;
    int passed = 0;

    figure_grid_compositor #(.BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset(reset), .HCount(HCount), .VCount(VCount),
        .video_on(video_on), .frame_start(frame_start), .fig_on(fig_on), .text_on(text_on),
        .move_left(move_left), .move_right(move_right), .move_up(move_up), .move_down(move_down),
        .enter(enter), .back(back), .sel_index(sel_index), .full_screen(full_screen), .rgb(rgb)
    );

    always #5 clk = ~clk;

    // Present one pixel and wait out the two-stage latency.
    task automatic drive_pix(input int x, input int y, input logic v, input logic [8:0] f, input logic t);
        HCount   = 10'(x);
        VCount   = 10'(y);
        video_on = v;
        fig_on   = f;
        text_on  = t;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // One-cycle command pulse; mask = {left,right,up,down,enter,back}.
    task automatic cmd(input logic [5:0] m, input logic fs);
        {move_left, move_right, move_up, move_down, enter, back} = m;
        frame_start = fs;
        @(posedge clk);
        #1;
        {move_left, move_right, move_up, move_down, enter, back} = '0;
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        video_on = 1'b1;
        fig_on = 9'h1FF;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rgb !== 3'b000) $display("FAIL reset_rgb: got %b want 000", rgb); else passed++;
        checks++; if (sel_index !== 4'd0) $display("FAIL reset_sel: got %0d want 0", sel_index); else passed++;
        checks++; if (full_screen !== 1'b0) $display("FAIL reset_full: got %b want 0", full_screen); else passed++;
        reset = 1'b0;
        fig_on = 9'h000;
    endtask

    task automatic test_geometry();
        int         xs[12] = '{100, 2,   213, 212, 208, 209, 400, 400, 2,   639, 100, 100};
        int         ys[12] = '{100, 27,  100, 100, 100, 100, 25,  27,  27,  300, 25,  176};
        logic       vs[12] = '{1,   1,   1,   1,   1,   1,   1,   1,   0,   1,   1,   1};
        logic [2:0] ex[12] = '{3'b000, 3'b100, 3'b110, 3'b100, 3'b000, 3'b100,
                               3'b110, 3'b000, 3'b000, 3'b000, 3'b100, 3'b110};
        for (int i = 0; i < 12; i++) begin
            drive_pix(xs[i], ys[i], vs[i], 9'h000, 1'b0);
            checks++;
            if (rgb !== ex[i])
                $display("FAIL geometry[%0d] (%0d,%0d): got %b want %b", i, xs[i], ys[i], rgb, ex[i]);
            else passed++;
        end
    endtask

    task automatic test_moves();
        logic [5:0] ms[11] = '{6'b100000, 6'b001000, 6'b000100, 6'b010000, 6'b010000, 6'b000100,
                               6'b111000, 6'b001100, 6'b000001, 6'b010100, 6'b100000};
        logic [3:0] es[11] = '{4'd2, 4'd8, 4'd2, 4'd0, 4'd1, 4'd4, 4'd3, 4'd0, 4'd0, 4'd1, 4'd0};
        for (int i = 0; i < 11; i++) begin
            cmd(ms[i], 1'b0);
            checks++;
            if (sel_index !== es[i])
                $display("FAIL move[%0d] mask %b: got sel %0d want %0d", i, ms[i], sel_index, es[i]);
            else passed++;
        end
        cmd(6'b000000, 1'b1);
        checks++; if (full_screen !== 1'b0) $display("FAIL back_in_grid: got %b want 0", full_screen); else passed++;
    endtask

    task automatic test_fig();
        drive_pix(320, 250, 1'b1, 9'h010, 1'b0);
        checks++; if (rgb !== 3'b001) $display("FAIL fig_cell4: got %b want 001", rgb); else passed++;
        drive_pix(213, 100, 1'b1, 9'h001, 1'b0);
        checks++; if (rgb !== 3'b001) $display("FAIL fig_over_border: got %b want 001", rgb); else passed++;
        drive_pix(2, 27, 1'b1, 9'h100, 1'b0);
        checks++; if (rgb !== 3'b001) $display("FAIL fig_over_ring: got %b want 001", rgb); else passed++;
        drive_pix(100, 100, 1'b1, 9'h000, 1'b1);
        checks++; if (rgb !== 3'b001) $display("FAIL text_on: got %b want 001", rgb); else passed++;
        drive_pix(2, 27, 1'b0, 9'h010, 1'b1);
        checks++; if (rgb !== 3'b000) $display("FAIL blanked: got %b want 000", rgb); else passed++;
    endtask

    task automatic test_shadow();
        cmd(6'b010000, 1'b0);
        drive_pix(215, 30, 1'b1, 9'h000, 1'b0);
        checks++; if (rgb !== 3'b000) $display("FAIL shadow_hold_c1: got %b want 000", rgb); else passed++;
        drive_pix(2, 27, 1'b1, 9'h000, 1'b0);
        checks++; if (rgb !== 3'b100) $display("FAIL shadow_hold_c0: got %b want 100", rgb); else passed++;
        cmd(6'b000000, 1'b1);
        drive_pix(215, 30, 1'b1, 9'h000, 1'b0);
        checks++; if (rgb !== 3'b100) $display("FAIL shadow_load_c1: got %b want 100", rgb); else passed++;
        drive_pix(2, 27, 1'b1, 9'h000, 1'b0);
        checks++; if (rgb !== 3'b000) $display("FAIL shadow_load_c0: got %b want 000", rgb); else passed++;
        cmd(6'b100000, 1'b1);
        checks++; if (sel_index !== 4'd0) $display("FAIL coincide_sel: got %0d want 0", sel_index); else passed++;
        drive_pix(215, 30, 1'b1, 9'h000, 1'b0);
        checks++; if (rgb !== 3'b100) $display("FAIL coincide_wait: got %b want 100", rgb); else passed++;
        cmd(6'b000000, 1'b1);
        drive_pix(2, 27, 1'b1, 9'h000, 1'b0);
        checks++; if (rgb !== 3'b100) $display("FAIL coincide_next: got %b want 100", rgb); else passed++;
    endtask

    task automatic test_zoom();
        cmd(6'b010010, 1'b0);
        checks++; if (sel_index !== 4'd0) $display("FAIL enter_beats_move: got %0d want 0", sel_index); else passed++;
        checks++; if (full_screen !== 1'b0) $display("FAIL zoom_early: got %b want 0", full_screen); else passed++;
        cmd(6'b000100, 1'b0);
        checks++; if (sel_index !== 4'd0) $display("FAIL zoom_frozen: got %0d want 0", sel_index); else passed++;
        cmd(6'b000000, 1'b1);
        checks++; if (full_screen !== 1'b1) $display("FAIL zoom_rise: got %b want 1", full_screen); else passed++;
        drive_pix(100, 100, 1'b1, 9'h001, 1'b0);
        checks++; if (rgb !== 3'b001) $display("FAIL zoom_selfig: got %b want 001", rgb); else passed++;
        drive_pix(320, 250, 1'b1, 9'h010, 1'b0);
        checks++; if (rgb !== 3'b000) $display("FAIL zoom_otherfig: got %b want 000", rgb); else passed++;
        drive_pix(213, 100, 1'b1, 9'h000, 1'b0);
        checks++; if (rgb !== 3'b000) $display("FAIL zoom_border: got %b want 000", rgb); else passed++;
        drive_pix(2, 27, 1'b1, 9'h000, 1'b0);
        checks++; if (rgb !== 3'b000) $display("FAIL zoom_ring: got %b want 000", rgb); else passed++;
        drive_pix(400, 300, 1'b1, 9'h000, 1'b1);
        checks++; if (rgb !== 3'b001) $display("FAIL zoom_text: got %b want 001", rgb); else passed++;
        cmd(6'b000001, 1'b0);
        checks++; if (full_screen !== 1'b1) $display("FAIL back_hold: got %b want 1", full_screen); else passed++;
        cmd(6'b000000, 1'b1);
        checks++; if (full_screen !== 1'b0) $display("FAIL back_fall: got %b want 0", full_screen); else passed++;
        drive_pix(2, 27, 1'b1, 9'h000, 1'b0);
        checks++; if (rgb !== 3'b100) $display("FAIL grid_again: got %b want 100", rgb); else passed++;
    endtask

    task automatic test_reset_in_zoom();
        cmd(6'b010000, 1'b0);
        cmd(6'b010000, 1'b0);
        cmd(6'b000100, 1'b0);
        checks++; if (sel_index !== 4'd5) $display("FAIL reach_sel5: got %0d want 5", sel_index); else passed++;
        cmd(6'b000010, 1'b0);
        cmd(6'b000000, 1'b1);
        checks++; if (full_screen !== 1'b1) $display("FAIL zoom5: got %b want 1", full_screen); else passed++;
        drive_pix(100, 100, 1'b1, 9'h1FF, 1'b0);
        checks++; if (rgb !== 3'b001) $display("FAIL zoom5_pix: got %b want 001", rgb); else passed++;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (sel_index !== 4'd0) $display("FAIL midreset_sel: got %0d want 0", sel_index); else passed++;
        checks++; if (full_screen !== 1'b0) $display("FAIL midreset_full: got %b want 0", full_screen); else passed++;
        checks++; if (rgb !== 3'b000) $display("FAIL midreset_rgb0: got %b want 000", rgb); else passed++;
        @(posedge clk);
        #1;
        checks++; if (rgb !== 3'b000) $display("FAIL midreset_rgb1: got %b want 000", rgb); else passed++;
        @(posedge clk);
        #1;
        checks++; if (rgb !== 3'b001) $display("FAIL midreset_resume: got %b want 001", rgb); else passed++;
    endtask

    task automatic test_blink();
        logic [2:0] want;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int n = 0; n < 6; n++) begin
            want = (!BLINK_ON || ((n / 2) % 2 == 0)) ? 3'b100 : 3'b000;
            drive_pix(2, 27, 1'b1, 9'h000, 1'b0);
            checks++;
            if (rgb !== want) $display("FAIL blink_frame%0d: got %b want %b", n, rgb, want);
            else passed++;
            cmd(6'b000000, 1'b1);
        end
    endtask

    initial begin
        reset = 1'b1;
        HCount = '0; VCount = '0; video_on = 1'b0; frame_start = 1'b0;
        fig_on = '0; text_on = 1'b0;
        {move_left, move_right, move_up, move_down, enter, back} = '0;
        test_reset();
        test_geometry();
        test_moves();
        test_fig();
        test_shadow();
        test_zoom();
        test_reset_in_zoom();
        test_blink();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
